// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-ported unified memory between instruction
// fetch (IF) and the load/store unit (LSU). One transaction is outstanding at a time.
// IF is guaranteed forward progress by forcing it to win after MAX_WAIT lost rounds,
// and a pipeline flush silently drops the response of an in-flight fetch.
module rv32i_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_valid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_stall,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  output logic                    ls_valid,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    ls_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    protocol_err
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_LSU} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  drop_q, drop_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic                  protocol_err_q, protocol_err_d;

  logic ls_wins;
  logic if_wins;

  // LSU normally has priority; a starved fetch (wait_cnt at MAX_WAIT) takes the slot.
  // A flush in IDLE keeps IF out of this round only.
  assign ls_wins = ls_req && !(if_req && (wait_cnt_q == MAX_WAIT_C));
  assign if_wins = !ls_wins && if_req && !if_flush;

  // Next-state logic: arbitration, memory handshake tracking, drop and error flags.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wait_cnt_d     = wait_cnt_q;
    drop_d         = drop_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    protocol_err_d = protocol_err_q;

    if ((state_q != ST_IDLE) && (owner_q == OWN_IF) && if_flush) begin
      drop_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ls_wins) begin
          owner_d     = OWN_LSU;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_be_d    = ls_be;
          state_d     = ST_REQ;
          if (if_req && (wait_cnt_q < MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end else if (if_wins) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          state_d     = ST_REQ;
          wait_cnt_d  = 4'd0;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (if_flush && !if_req) begin
      wait_cnt_d = 4'd0;
    end

    if (mem_rvalid && (state_q != ST_RESP)) begin
      protocol_err_d = 1'b1;
    end
  end

  // State and registered memory-side outputs, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWN_IF;
      wait_cnt_q     <= 4'd0;
      drop_q         <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      wait_cnt_q     <= wait_cnt_d;
      drop_q         <= drop_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign protocol_err = protocol_err_q;

  // Responses complete in the same cycle as mem_rvalid; a dropped or flushed fetch gets no pulse.
  assign if_valid = (state_q == ST_RESP) && mem_rvalid && (owner_q == OWN_IF) && !drop_q && !if_flush;
  assign ls_valid = (state_q == ST_RESP) && mem_rvalid && (owner_q == OWN_LSU);
  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;
  assign if_stall = if_req && !if_valid;
  assign ls_stall = ls_req && !ls_valid;

endmodule
